// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the TinyALU responder.
package tinyalu_pkg;

    localparam int unsigned OPND_W              = 8;
    localparam int unsigned RES_W               = 16;
    localparam int unsigned OP_W                = 3;
    localparam int unsigned DEFAULT_MUL_LATENCY = 3;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SINGLE,
        ST_MULT,
        ST_RELEASE
    } alu_state_t;

    // Single-cycle datapath; opcodes outside add/and/xor yield zero.
    function automatic logic [RES_W-1:0] alu_single(input logic [OPND_W-1:0] a,
                                                    input logic [OPND_W-1:0] b,
                                                    input operation_t op);
        logic [RES_W-1:0] r;
        r = '0;
        case (op)
            add_op:  r = RES_W'(a) + RES_W'(b);
            and_op:  r = RES_W'(a & b);
            xor_op:  r = RES_W'(a ^ b);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_if.sv
// Start/done command bus between the TinyALU initiator and responder.
interface tinyalu_if;
    import tinyalu_pkg::*;

    logic                  start;
    logic [OPND_W-1:0]     A;
    logic [OPND_W-1:0]     B;
    logic [OP_W-1:0]       op;
    logic                  done;
    logic [RES_W-1:0]      result;

    modport master (output start, output A, output B, output op,
                    input  done,  input  result);
    modport slave  (input  start, input  A, input  B, input  op,
                    output done,  output result);
endinterface

// File: rtl/tinyalu_mult.sv
// 8x8 unsigned multiplier: operand stage plus MUL_LATENCY-1 product stages,
// with a parallel valid chain that flush clears.
module tinyalu_mult
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [OPND_W-1:0]    a,
    input  logic [OPND_W-1:0]    b,
    output logic                 out_valid,
    output logic [RES_W-1:0]     p
);

    logic [OPND_W-1:0]      opa_q, opa_d;
    logic [OPND_W-1:0]      opb_q, opb_d;
    logic [RES_W-1:0]       prod_q [1:MUL_LATENCY-1];
    logic [RES_W-1:0]       prod_d [1:MUL_LATENCY-1];
    logic [MUL_LATENCY-1:0] vld_q, vld_d;

    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (in_valid) begin
            opa_d = a;
            opb_d = b;
        end
        prod_d[1] = RES_W'(opa_q) * RES_W'(opb_q);
        for (int k = 2; k < int'(MUL_LATENCY); k++) begin
            prod_d[k] = prod_q[k-1];
        end
        vld_d = flush ? '0 : {vld_q[MUL_LATENCY-2:0], in_valid};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa_q <= '0;
            opb_q <= '0;
            vld_q <= '0;
            for (int k = 1; k < int'(MUL_LATENCY); k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            opa_q <= opa_d;
            opb_q <= opb_d;
            vld_q <= vld_d;
            for (int k = 1; k < int'(MUL_LATENCY); k++) begin
                prod_q[k] <= prod_d[k];
            end
        end
    end

    assign out_valid = vld_q[MUL_LATENCY-1];
    assign p         = prod_q[MUL_LATENCY-1];

endmodule

// File: rtl/tinyalu_core.sv
// TinyALU responder: captures a command on start, answers with result and a
// one-cycle done, then waits for start to drop before accepting the next one.
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
    input  logic       clk,
    input  logic       reset_n,
    tinyalu_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(MUL_LATENCY);

    alu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPND_W-1:0]  a_q, a_d;
    logic [OPND_W-1:0]  b_q, b_d;
    operation_t         op_q, op_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               cap_c;
    logic               flush_c;
    logic               mul_valid_c;
    logic [RES_W-1:0]   mul_p_c;

    tinyalu_mult #(.MUL_LATENCY(MUL_LATENCY)) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush_c),
        .in_valid  (cap_c),
        .a         (bus.A),
        .b         (bus.B),
        .out_valid (mul_valid_c),
        .p         (mul_p_c)
    );

    // Next-state, capture and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        done_d   = 1'b0;
        result_d = result_q;
        cap_c    = 1'b0;
        flush_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.A;
                    b_d   = bus.B;
                    op_d  = operation_t'(bus.op);
                    cnt_d = '0;
                    case (operation_t'(bus.op))
                        add_op, and_op, xor_op: state_d = ST_SINGLE;
                        mul_op: begin
                            cap_c   = 1'b1;
                            state_d = ST_MULT;
                        end
                        default: state_d = ST_RELEASE;
                    endcase
                end
            end
            ST_SINGLE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = alu_single(a_q, b_q, op_q);
                    done_d   = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end
            ST_MULT: begin
                if (!bus.start) begin
                    flush_c = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(MUL_LATENCY - 1) && mul_valid_c) begin
                    result_d = mul_p_c;
                    done_d   = 1'b1;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= no_op;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: doc/tinyalu_core.md
# tinyalu_core

Synthesizable TinyALU responder: the DUT end of the start/done command protocol that the TinyALU bench drives. It samples `A`, `B` and `op` when `start` rises, computes add/and/xor in one cycle and multiply in a fixed multi-cycle pipeline, and returns `result` with a one-cycle `done` pulse. It sits directly under the bench interface as the block under test, and is reused as the ALU slice in larger datapaths.

## Interface
Parameters:
- `MUL_LATENCY`, default 3: clock edges from the capture edge to `done` for multiply. Legal values are ≥ 2.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `start` input 1: command request. Held high by the initiator until it observes `done`.
- `A` input 8: operand A, unsigned.
- `B` input 8: operand B, unsigned.
- `op` input 3: opcode, `operation_t` encoding.
- `done` output 1: one-cycle completion pulse.
- `result` output 16: operation result. Held stable until the next completion or reset.

## Operation
- Opcodes:
  - 000 `no_op`: accepted, no `done`, `result` unchanged.
  - 001 `add_op`
  - 010 `and_op`
  - 011 `xor_op`
  - 100 `mul_op`
  - 101, 110, 111 (`rst_op` is delivered via `reset_n`, not `op`): treated as `no_op`.
- Width rules:
  - add: 9-bit sum, zero-extended to 16 bits (255+255 = 0x01FE).
  - and/xor: 8-bit result, zero-extended.
  - mul: full 16-bit unsigned product (255*255 = 0xFE01).
- FSM states:
  - IDLE, on `start`=1:
    - capture `A`, `B`, `op`;
    - `no_op`/illegal op: go to RELEASE;
    - add/and/xor: go to SINGLE;
    - mul: go to MULT with the cycle counter cleared.
  - SINGLE: register `result` and pulse `done`, then go to RELEASE.
  - MULT: count edges; when the count reaches `MUL_LATENCY`−1, register the product and pulse `done`, then go to RELEASE.
  - RELEASE: stay until `start` is sampled 0, then go to IDLE. This stops a still-high `start` from relaunching the command on the edge where `done` is seen.
- Abort: `start` sampled 0 in SINGLE or MULT returns the FSM to IDLE with no `done` and `result` unchanged. The multiply pipeline contents are discarded.
- Operands are used only as captured. Changes on `A`/`B`/`op` after the capture edge are ignored.

## Timing
- Reset (asynchronous assert, synchronous release): `done`=0, `result`=0, FSM in IDLE, counter 0, capture registers 0.
- Edge numbering: E0 is the rising edge that samples `start`=1 in IDLE.
- Single-cycle ops: `done`=1 and `result` valid after E1. `done` returns to 0 after E2.
- Multiply: `done` and `result` valid after E(`MUL_LATENCY`). With the default, that is E3.
- `done` is never high for two consecutive cycles.
- Back-to-back commands need `start` low on at least one rising edge between them.
- `reset_n` asserted mid-operation clears everything immediately. No `done` is issued for the aborted command.
- `no_op` with a one-cycle `start` pulse: IDLE → RELEASE → IDLE. `done` is never raised.

## Structure
- `tinyalu_pkg` holds:
  - `operation_t` (existing);
  - the FSM state enum `alu_state_t`;
  - a localparam for the default multiply latency.
- One sub-module, `tinyalu_mult`: an 8x8 unsigned multiplier with `MUL_LATENCY` register stages and a valid shift chain. It is flushed by `reset_n` and by abort.
- Everything else (capture registers, single-cycle datapath, FSM, output registers) lives in `tinyalu_core`.

## Test plan
- Reset, then `add_op` with A=0xFF, B=0xFF → `done` after E1, `result`=0x01FE, `done` width exactly 1 cycle.
- `and_op` A=0xF0, B=0x3C → 0x0030; then `xor_op` same operands → 0x00CC. Between the two, `start` is held high 1 extra cycle after `done`; the bench checks there is no relaunch.
- `mul_op` A=0xFF, B=0xFF → `done` only after E3, `result`=0xFE01. `A`/`B` are changed to 0 after E0; the result is unaffected.
- `no_op` pulse, and op=111 held with `start` for 4 cycles → `done` never asserts, `result` keeps its previous value.
- `mul_op` A=3, B=4 with `reset_n` pulsed low after E1 → `done`=0 and `result`=0 immediately. A following `mul_op` 3×4 → 0x000C at E3.
- `start` dropped after E1 during `mul_op` → no `done`. The next `add_op` 1+2 → 0x0003 at E1.
